// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command register bank.
package uart_cmd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_ADDR    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int CMD_WR_BIT = 7;

    function automatic int cmd_bytes(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_cmd_regbank_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, pulses on expiry.
module byte_timeout #(
    parameter int TIMEOUT = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit;

    // A kick in the expiry cycle wins, so the pulse is masked by kick.
    assign at_limit = (cnt_q == CW'(TIMEOUT - 1));
    assign expired  = (TIMEOUT != 0) && enable && !kick && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (kick || !enable || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_regbank.sv
// UART byte-command decoder driving a bank of NUM_REGS registers.
module uart_cmd_regbank
    import uart_cmd_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter int          DATA_W    = 16,
    parameter int          TIMEOUT   = 50000000,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_valid,
    input  logic [8:0]                 frame,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       ack,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       busy
);

    localparam int BYTES = cmd_bytes(DATA_W);
    localparam int SW    = BYTES * 8;
    localparam int AW    = $clog2(NUM_REGS);
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   bad_q, bad_d;
    logic [SW-1:0]          shift_q, shift_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   busy_q, busy_d;

    logic [6:0]             cmd_addr;
    logic                   cmd_bad;
    logic [SW-1:0]          shift_next;
    logic                   expired;

    assign cmd_addr   = frame[6:0];
    assign cmd_bad    = int'(cmd_addr) >= NUM_REGS;
    // MSB-first assembly; bits shifted past the top are dropped.
    assign shift_next = SW'({shift_q, frame[7:0]});

    byte_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == WDATA),
        .kick   (frame_valid),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bad_d       = bad_q;
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    if (frame[8]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PARITY;
                    end else if (frame[CMD_WR_BIT]) begin
                        addr_d  = cmd_addr[AW-1:0];
                        bad_d   = cmd_bad;
                        shift_d = '0;
                        bcnt_d  = '0;
                        state_d = WDATA;
                    end else if (cmd_bad) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ADDR;
                    end else begin
                        rd_valid_d = 1'b1;
                        ack_d      = 1'b1;
                        rd_data_d  = regs_q[cmd_addr[AW-1:0]];
                    end
                end
            end
            WDATA: begin
                if (frame_valid) begin
                    if (frame[8]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PARITY;
                        state_d    = IDLE;
                    end else begin
                        shift_d = shift_next;
                        bcnt_d  = bcnt_q + CW'(1);
                        if (bcnt_q == CW'(BYTES - 1)) begin
                            state_d = IDLE;
                            if (bad_q) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_ADDR;
                            end else begin
                                regs_d[addr_q] = shift_next[DATA_W-1:0];
                                wr_strobe_d    = NUM_REGS'(1) << addr_q;
                                ack_d          = 1'b1;
                            end
                        end
                    end
                end else if (expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WDATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bad_q       <= 1'b0;
            shift_q     <= '0;
            bcnt_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(RESET_VAL);
            end
            wr_strobe_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bad_q       <= bad_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign wr_strobe = wr_strobe_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_regbank.sv
// Directed bench for uart_cmd_regbank with a 20-cycle inter-byte timeout.
module tb_uart_cmd_regbank;

    localparam int NR = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_valid = 1'b0;
    logic [8:0]        frame = '0;
    logic [NR*DW-1:0]  regs;
    logic [NR-1:0]     wr_strobe;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              ack;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_regs [NR];

    uart_cmd_regbank #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .TIMEOUT  (20),
        .RESET_VAL(32'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame      (frame),
        .regs       (regs),
        .wr_strobe  (wr_strobe),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ack        (ack),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*DW-1:0] packed_exp();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i*DW +: DW] = exp_regs[i];
        end
        return v;
    endfunction

    task automatic chk(input string tag,
                       input logic [NR*DW-1:0] obs,
                       input logic [NR*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame for one cycle; returns at the negedge after capture.
    task automatic send(input logic [7:0] b, input logic perr);
        @(negedge clk);
        frame_valid = 1'b1;
        frame       = {perr, b};
        @(negedge clk);
        frame_valid = 1'b0;
        frame       = '0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_regs", regs, '0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_rddata", rd_data, 0);
        chk("rst_strobe", wr_strobe, 0);
        rst = 1'b1;

        // 1: write reg3 = 0x1234
        send(8'h83, 1'b0);
        chk("t1_busy", busy, 1);
        send(8'h12, 1'b0);
        chk("t1_mid_regs", regs, packed_exp());
        send(8'h34, 1'b0);
        exp_regs[3] = 16'h1234;
        chk("t1_regs", regs, packed_exp());
        chk("t1_strobe", wr_strobe, 16'h0008);
        chk("t1_ack", ack, 1);
        chk("t1_busy_end", busy, 0);
        @(negedge clk);
        chk("t1_ack_pulse", ack, 0);
        chk("t1_strobe_pulse", wr_strobe, 0);

        // 2: read reg3
        send(8'h03, 1'b0);
        chk("t2_rdv", rd_valid, 1);
        chk("t2_ack", ack, 1);
        chk("t2_rddata", rd_data, 16'h1234);
        chk("t2_regs", regs, packed_exp());
        @(negedge clk);
        chk("t2_rdv_pulse", rd_valid, 0);

        // 3: bad address write and read
        send(8'h95, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        chk("t3_err", err, 1);
        chk("t3_code", err_code, 2'b10);
        chk("t3_strobe", wr_strobe, 0);
        chk("t3_ack", ack, 0);
        chk("t3_regs", regs, packed_exp());
        send(8'h03, 1'b1);
        chk("t3_cmd_par_code", err_code, 2'b01);
        chk("t3_cmd_par_rdv", rd_valid, 0);
        send(8'h7F, 1'b0);
        chk("t3_rd_err", err, 1);
        chk("t3_rd_code", err_code, 2'b10);
        chk("t3_rd_rdv", rd_valid, 0);

        // 4: parity error mid-write, then a good write
        send(8'h81, 1'b0);
        send(8'hAA, 1'b1);
        chk("t4_err", err, 1);
        chk("t4_code", err_code, 2'b01);
        chk("t4_busy", busy, 0);
        chk("t4_regs", regs, packed_exp());
        send(8'h81, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        exp_regs[1] = 16'h0001;
        chk("t4_regs2", regs, packed_exp());
        chk("t4_strobe", wr_strobe, 16'h0002);
        chk("t4_code_hold", err_code, 2'b01);
        chk("t4_err2", err, 0);

        // 5a: timeout after 20 idle cycles
        send(8'h82, 1'b0);
        send(8'h55, 1'b0);
        repeat (19) @(negedge clk);
        chk("t5_pre_err", err, 0);
        chk("t5_pre_busy", busy, 1);
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_code", err_code, 2'b11);
        chk("t5_busy", busy, 0);
        chk("t5_regs", regs, packed_exp());
        send(8'h02, 1'b0);
        chk("t5_rd_v", rd_valid, 1);
        chk("t5_rd_data", rd_data, 16'h0000);

        // 5b: byte lands on the expiry cycle and is accepted
        send(8'h82, 1'b0);
        send(8'h55, 1'b0);
        repeat (18) @(negedge clk);
        send(8'h66, 1'b0);
        exp_regs[2] = 16'h5566;
        chk("t5b_err", err, 0);
        chk("t5b_ack", ack, 1);
        chk("t5b_strobe", wr_strobe, 16'h0004);
        chk("t5b_regs", regs, packed_exp());

        // 6: reset mid-write
        send(8'h84, 1'b0);
        send(8'h11, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        chk("t6_rst_regs", regs, packed_exp());
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_code", err_code, 0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h00, 1'b0);
        chk("t6_rdv", rd_valid, 1);
        chk("t6_ack", ack, 1);
        chk("t6_rddata", rd_data, 16'h0000);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        chk("t6_regs", regs, packed_exp());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
